// File: rtl/mdu_pkg.sv
// mdu_pkg: shared MDU op/read encodings, latency defaults and controller state type.
package mdu_pkg;
  typedef logic [3:0] op_t;
  typedef logic [1:0] rd_t;
  typedef enum logic {IDLE, BUSY} state_t;
  localparam op_t OP_NONE  = 4'd0;
  localparam op_t OP_MULT  = 4'd1;
  localparam op_t OP_MULTU = 4'd2;
  localparam op_t OP_DIV   = 4'd3;
  localparam op_t OP_DIVU  = 4'd4;
  localparam op_t OP_MTHI  = 4'd5;
  localparam op_t OP_MTLO  = 4'd6;
  localparam rd_t RD_NONE  = 2'd0;
  localparam rd_t RD_MFLO  = 2'd1;
  localparam rd_t RD_MFHI  = 2'd2;
  localparam int MULT_TIME_DEF = 5;
  localparam int DIV_TIME_DEF  = 10;
endpackage

// File: rtl/mdu_busy_timer.sv
// mdu_busy_timer: 4-bit load/decrement busy counter mirroring the MDU timer.
module mdu_busy_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] cnt,
  output logic       busy
);
  assign busy = |cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= load ? load_val : cnt - {3'b0, busy};
endmodule

// File: rtl/mdu_issue_ctrl.sv
// mdu_issue_ctrl: E-stage MDU issue control with HI/LO interlock, flush suppression,
// busy consistency check and performance counters.
module mdu_issue_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_TIME = MULT_TIME_DEF,
  parameter int DIV_TIME  = DIV_TIME_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [3:0]  in_op,
  input  logic [1:0]  in_read,
  input  logic        req,
  input  logic        mdu_busy,
  output logic        in_ready,
  output logic        stall,
  output logic        mdu_start,
  output logic [3:0]  mdu_op,
  output logic [3:0]  mdu_time,
  output logic [1:0]  mdu_readhilo,
  output logic        sync_err,
  output logic [31:0] stall_cycles,
  output logic [15:0] issued_ops
);
  localparam logic [3:0] MT = 4'(MULT_TIME);
  localparam logic [3:0] DT = 4'(DIV_TIME);
  logic [3:0] cnt;
  logic busy, hilo, md, is_div, acc;
  state_t state;
  mdu_busy_timer u_timer (
    .clk(clk), .reset(reset), .load(mdu_start), .load_val(mdu_time),
    .cnt(cnt), .busy(busy)
  );
  assign state = busy ? BUSY : IDLE;
  assign hilo = (in_op != OP_NONE) || (in_read != RD_NONE);
  assign md = (in_op == OP_MULT) || (in_op == OP_MULTU) || is_div;
  assign is_div = (in_op == OP_DIV) || (in_op == OP_DIVU);
  assign in_ready = !hilo || state == IDLE || req;
  assign stall = in_valid && !in_ready;
  // reset gates issue so the MDU sees a quiet port while both are held in reset
  assign acc = reset && in_valid && in_ready && !req;
  always_comb begin
    mdu_start = acc && md;
    mdu_op = acc ? in_op : OP_NONE;
    mdu_time = mdu_start ? (is_div ? DT : MT) : 4'd0;
    mdu_readhilo = acc ? in_read : RD_NONE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sync_err <= 1'b0;
      stall_cycles <= '0;
      issued_ops <= '0;
    end else begin
      sync_err <= sync_err | (mdu_busy != (busy | mdu_start));
      stall_cycles <= stall_cycles + {31'b0, stall && !(&stall_cycles)};
      issued_ops <= issued_ops + {15'b0, mdu_start};
    end
endmodule
